// File: rtl/ttt_move_sequencer.sv
// ttt_move_sequencer: conditions the push-buttons into a board cursor and a player
// move command. It then finds the computer's reply as the first empty cell and
// drives the play/pc strobes of the tic-tac-toe game core.
// Parameter minimums: DEBOUNCE_CYCLES >= 1, HOLD_CYCLES >= 1, GAP_CYCLES >= 1.
module ttt_move_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 4,
  parameter int GAP_CYCLES      = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_sel,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  input  logic [1:0] who,
  output logic       play,
  output logic       pc,
  output logic [3:0] player_position,
  output logic [3:0] computer_position,
  output logic [3:0] cursor,
  output logic       busy,
  output logic       illegal
);

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SEQ_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(SEQ_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       LAST_CELL = 4'd8;

  // ---------------------------------------------------------------------------
  // Button conditioning: bit 0 = next, bit 1 = prev, bit 2 = sel
  // ---------------------------------------------------------------------------
  logic [2:0] btn_raw;
  logic [2:0] btn_event;

  assign btn_raw = {btn_sel, btn_prev, btn_next};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic             sync1_reg;
    logic             sync2_reg;
    logic             sync_prev_reg;
    logic             level_reg;
    logic             event_reg;
    logic [DEB_W-1:0] cnt_reg;

    // Synchronize the raw level, then accept it only once it has stayed put
    // long enough; a press (0->1 of the accepted level) yields a one-cycle event.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync1_reg     <= 1'b0;
        sync2_reg     <= 1'b0;
        sync_prev_reg <= 1'b0;
        level_reg     <= 1'b0;
        event_reg     <= 1'b0;
        cnt_reg       <= '0;
      end else begin
        sync1_reg     <= btn_raw[gi];
        sync2_reg     <= sync1_reg;
        sync_prev_reg <= sync2_reg;
        event_reg     <= 1'b0;
        if (sync2_reg != sync_prev_reg) begin
          // Any bounce restarts the stability window.
          cnt_reg <= '0;
        end else if (sync2_reg == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt_reg   <= '0;
          level_reg <= sync2_reg;
          event_reg <= sync2_reg;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end

    assign btn_event[gi] = event_reg;
  end

  logic next_ev;
  logic prev_ev;
  logic sel_ev;

  assign next_ev = btn_event[0];
  assign prev_ev = btn_event[1];
  assign sel_ev  = btn_event[2];

  // ---------------------------------------------------------------------------
  // Board view: cell n is pos(n+1); anything other than 00 counts as occupied
  // ---------------------------------------------------------------------------
  logic [17:0] board_flat;
  logic [8:0]  cell_empty;
  logic        game_over;

  assign board_flat = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
  assign game_over  = (who != 2'b00);

  for (genvar gi = 0; gi < 9; gi++) begin : g_cell
    assign cell_empty[gi] = (board_flat[2*gi +: 2] == 2'b00);
  end

  // ---------------------------------------------------------------------------
  // Cursor
  // ---------------------------------------------------------------------------
  logic [3:0] cursor_reg;

  // Step the cursor around 0..8 with wrap; simultaneous next+prev cancel out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cursor_reg <= 4'd0;
    end else if (next_ev && !prev_ev) begin
      cursor_reg <= (cursor_reg == LAST_CELL) ? 4'd0 : cursor_reg + 4'd1;
    end else if (prev_ev && !next_ev) begin
      cursor_reg <= (cursor_reg == 4'd0) ? LAST_CELL : cursor_reg - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Move sequencing FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_P_STROBE = 3'd1,
    S_GAP      = 3'd2,
    S_SEARCH   = 3'd3,
    S_C_STROBE = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       idx_reg, idx_next;
  logic [3:0]       ppos_reg, ppos_next;
  logic [3:0]       cpos_reg, cpos_next;
  logic             illegal_next;

  // State, phase counter, search index and latched move cells.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= 4'd0;
      ppos_reg  <= 4'd0;
      cpos_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      ppos_reg  <= ppos_next;
      cpos_reg  <= cpos_next;
    end
  end

  // Next-state logic: accept a legal select, strobe play, wait for the board to
  // settle, scan for the computer's cell, strobe pc.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    ppos_next    = ppos_reg;
    cpos_next    = cpos_reg;
    illegal_next = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // Selects after game over are silently ignored.
        if (sel_ev && !game_over) begin
          if (cell_empty[cursor_reg]) begin
            ppos_next  = cursor_reg;
            cnt_next   = '0;
            state_next = S_P_STROBE;
          end else begin
            illegal_next = 1'b1;
          end
        end
      end

      S_P_STROBE: begin
        if (cnt_reg == HOLD_LAST) begin
          cnt_next   = '0;
          state_next = S_GAP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next   = '0;
          idx_next   = 4'd0;
          // The player's move may have ended the game.
          state_next = game_over ? S_IDLE : S_SEARCH;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_SEARCH: begin
        if (game_over) begin
          state_next = S_IDLE;
        end else if (cell_empty[idx_reg]) begin
          cpos_next  = idx_reg;
          cnt_next   = '0;
          state_next = S_C_STROBE;
        end else if (idx_reg == LAST_CELL) begin
          // Board full: no reply.
          state_next = S_IDLE;
        end else begin
          idx_next = idx_reg + 4'd1;
        end
      end

      S_C_STROBE: begin
        if (cnt_reg == HOLD_LAST) begin
          cnt_next   = '0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign play              = (state_reg == S_P_STROBE);
  assign pc                = (state_reg == S_C_STROBE);
  assign busy              = (state_reg != S_IDLE);
  assign illegal           = illegal_next;
  assign cursor            = cursor_reg;
  assign player_position   = ppos_reg;
  assign computer_position = cpos_reg;

endmodule

// File: tb/tb_ttt_move_sequencer.sv
// Self-checking bench for ttt_move_sequencer: the bench plays the role of the
// game core and keeps the board. A model of cursor arithmetic and first-empty
// search gives the expected moves and strobe timing.
module tb_ttt_move_sequencer;

  localparam int DEB  = 4;
  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       btn_sel = 1'b0;
  logic [1:0] board [9];
  logic [1:0] who = 2'b00;
  logic       play, pc, busy, illegal;
  logic [3:0] player_position, computer_position, cursor;

  ttt_move_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .btn_next         (btn_next),
    .btn_prev         (btn_prev),
    .btn_sel          (btn_sel),
    .pos1             (board[0]),
    .pos2             (board[1]),
    .pos3             (board[2]),
    .pos4             (board[3]),
    .pos5             (board[4]),
    .pos6             (board[5]),
    .pos7             (board[6]),
    .pos8             (board[7]),
    .pos9             (board[8]),
    .who              (who),
    .play             (play),
    .pc               (pc),
    .player_position  (player_position),
    .computer_position(computer_position),
    .cursor           (cursor),
    .busy             (busy),
    .illegal          (illegal)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_play, n_pc, n_ill;
  int play_first, play_last, pc_first, idle_at;
  int last_pp, last_cp;
  int model_cursor = 0;
  logic play_d = 1'b0;
  logic pc_d = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic clear_win();
    n_play = 0; n_pc = 0; n_ill = 0;
    play_first = -1; play_last = -1; pc_first = -1; idle_at = -1;
    last_pp = -1; last_cp = -1;
  endtask

  // Advance one clock, sample 1 time unit after the edge, and act as the game:
  // a rising play/pc strobe writes the mark into the board.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (play === 1'b1) begin
      n_play++;
      if (play_first < 0) play_first = cyc;
      play_last = cyc;
      last_pp = int'(player_position);
      if (!play_d && player_position < 4'd9) board[player_position] = 2'b01;
    end
    if (pc === 1'b1) begin
      n_pc++;
      if (pc_first < 0) pc_first = cyc;
      last_cp = int'(computer_position);
      if (!pc_d && computer_position < 4'd9) board[computer_position] = 2'b10;
    end
    if (illegal === 1'b1) n_ill++;
    if (play_last >= 0 && busy === 1'b0 && idle_at < 0) idle_at = cyc;
    play_d = play;
    pc_d = pc;
  endtask

  // mask bit0 = next, bit1 = prev, bit2 = sel
  task automatic press(input int mask);
    btn_next = mask[0];
    btn_prev = mask[1];
    btn_sel  = mask[2];
    repeat (12) tick();
    btn_next = 1'b0;
    btn_prev = 1'b0;
    btn_sel  = 1'b0;
    repeat (12) tick();
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_idle_timeout"}, busy, 0);
  endtask

  task automatic goto_cell(input int target);
    int guard = 0;
    int d;
    while (model_cursor != target && guard < 9) begin
      d = (target - model_cursor + 9) % 9;
      if (d <= 4) begin
        press(1);
        model_cursor = (model_cursor + 1) % 9;
      end else begin
        press(2);
        model_cursor = (model_cursor + 8) % 9;
      end
      guard++;
    end
    chk("goto_cursor", cursor, target);
  endtask

  task automatic clear_board();
    for (int i = 0; i < 9; i++) board[i] = 2'b00;
  endtask

  // First empty cell once cell p has been taken by the player; -1 if none.
  function automatic int first_empty_after(input int p);
    for (int i = 0; i < 9; i++)
      if (board[i] == 2'b00 && i != p) return i;
    return -1;
  endfunction

  // Press sel at the current cursor and check the full move/reply outcome.
  task automatic play_turn(input string tag);
    int target;
    int exp_cp;
    logic occupied;
    target   = model_cursor;
    occupied = (board[target] != 2'b00);
    exp_cp   = first_empty_after(target);
    clear_win();
    press(4);
    wait_idle(tag);
    if (occupied) begin
      chk({tag, "_illegal_cycles"}, n_ill, 1);
      chk({tag, "_no_play"}, n_play, 0);
    end else begin
      chk({tag, "_play_cycles"}, n_play, HOLD);
      chk({tag, "_play_contig"}, play_last - play_first + 1, HOLD);
      chk({tag, "_player_pos"}, last_pp, target);
      chk({tag, "_no_illegal"}, n_ill, 0);
      if (exp_cp < 0) begin
        chk({tag, "_no_pc"}, n_pc, 0);
        chk({tag, "_full_idle_delay"}, idle_at - play_last, GAP + 9 + 1);
      end else begin
        chk({tag, "_pc_cycles"}, n_pc, HOLD);
        chk({tag, "_computer_pos"}, last_cp, exp_cp);
        chk({tag, "_pc_delay"}, pc_first - play_last, GAP + exp_cp + 2);
      end
    end
  endtask

  initial begin
    int k;
    int r;
    clear_board();
    clear_win();

    // Reset state
    repeat (3) tick();
    chk("rst_play", play, 0);
    chk("rst_pc", pc, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_busy", busy, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_ppos", player_position, 0);
    chk("rst_cpos", computer_position, 0);
    reset = 1'b0;
    repeat (4) tick();

    // Long hold of next: exactly one step
    clear_win();
    btn_next = 1'b1;
    repeat (20) tick();
    btn_next = 1'b0;
    repeat (12) tick();
    model_cursor = 1;
    chk("hold_next_cursor", cursor, model_cursor);
    chk("hold_next_no_play", n_play, 0);
    chk("hold_next_no_pc", n_pc, 0);

    // Wrap tests
    press(2); model_cursor = 0;
    chk("prev_to_0", cursor, model_cursor);
    press(2); model_cursor = 8;
    chk("prev_wrap_8", cursor, model_cursor);
    press(1); model_cursor = 0;
    chk("next_wrap_0", cursor, model_cursor);
    press(3);
    chk("both_unchanged", cursor, model_cursor);

    // Empty board, move at cell 4, reply at cell 0
    clear_board();
    goto_cell(4);
    play_turn("move4");
    chk("move4_board_cell4", board[4], 2'b01);

    // Select on an occupied cell
    clear_board();
    board[0] = 2'b01;
    goto_cell(0);
    play_turn("occupied0");

    // Only cell 8 empty: move, then no reply after a full scan
    for (int i = 0; i < 8; i++) board[i] = 2'b10;
    board[8] = 2'b00;
    goto_cell(8);
    play_turn("full8");
    chk("full8_board_cell8", board[8], 2'b01);

    // Game over: select ignored
    clear_board();
    who = 2'b01;
    clear_win();
    press(4);
    chk("over_no_play", n_play, 0);
    chk("over_no_illegal", n_ill, 0);
    chk("over_not_busy", busy, 0);
    who = 2'b00;

    // Reset in the second play cycle
    goto_cell(3);
    clear_board();
    clear_win();
    btn_sel = 1'b1;
    k = 0;
    while (play !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk("rstmid_play_seen", play, 1);
    tick();
    reset = 1'b1;
    #1;
    chk("rstmid_play", play, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_cursor", cursor, 0);
    btn_sel = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    model_cursor = 0;
    clear_win();
    repeat (12) tick();
    chk("rstmid_after_no_play", n_play, 0);
    chk("rstmid_after_busy", busy, 0);

    // Random cursor presses
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 2);
      if (r == 0) begin
        press(1); model_cursor = (model_cursor + 1) % 9;
      end else if (r == 1) begin
        press(2); model_cursor = (model_cursor + 8) % 9;
      end else begin
        press(3);
      end
      chk("rand_cursor", cursor, model_cursor);
    end

    // Random boards and targets
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 9; i++) begin
        r = $urandom_range(0, 5);
        board[i] = (r < 3) ? 2'b00 : 2'(r - 2);
      end
      goto_cell($urandom_range(0, 8));
      play_turn("rand_turn");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ttt_move_sequencer.md
Name: ttt_move_sequencer

Overview:
- Upstream input/turn stage for tic_tac_toe_game.
- Converts raw push-buttons into a board cursor and a player move command, then computes the computer's reply by scanning for the first empty cell.
- Drives the game's play/pc strobes and player_position/computer_position.
- Reads back pos1..pos9 and who, so it never issues moves onto occupied cells or after the game has ended.

Parameters:
- DEBOUNCE_CYCLES, 16, clock cycles a synchronized button level must stay stable before it is accepted (min 1).
- HOLD_CYCLES, 4, cycles each play/pc strobe is held high (min 1).
- GAP_CYCLES, 2, idle cycles between play falling and the start of the computer search (lets the board update).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn_next  in  1  raw button; cursor +1.
- btn_prev  in  1  raw button; cursor -1.
- btn_sel  in  1  raw button; place the player's mark at the cursor.
- pos1..pos9  in  2 each  board cells from the game: 00 empty, 01 player, 10 computer, 11 treated as occupied.
- who  in  2  00 game running; any non-zero value means game over.
- play  out  1  player move strobe to the game.
- pc  out  1  computer move strobe to the game.
- player_position  out  4  cell 0..8 for play.
- computer_position  out  4  cell 0..8 for pc.
- cursor  out  4  current cursor cell 0..8, for display.
- busy  out  1  high in any state other than IDLE.
- illegal  out  1  one-cycle pulse when a select lands on an occupied cell.

Behaviour:
- Reset (asynchronous, active-high) forces all outputs to 0, cursor to 0, FSM to IDLE, and clears debounce counters and sync flops. This applies at any time, including mid-strobe; play and pc drop to 0 in the same cycle.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter: reloads on every change of the synchronized level; the debounced level updates after DEBOUNCE_CYCLES stable cycles.
  - A debounced 0->1 transition produces a 1-cycle event. Releasing the button produces no event.
- Cursor:
  - next event: +1, with 8 wraps to 0.
  - prev event: -1, with 0 wraps to 8.
  - next and prev events in the same cycle: cursor unchanged.
  - The cursor moves in any FSM state and is never >8.
- Cell n maps to pos(n+1).
- FSM states:
  - IDLE:
    - sel event, who==0, cell at cursor empty: latch player_position=cursor, go to P_STROBE.
    - sel event on an occupied cell: illegal=1 for that cycle only; stay in IDLE.
    - sel event with who!=0: ignored; no illegal pulse.
  - P_STROBE: play=1 for exactly HOLD_CYCLES cycles, starting the cycle after the sel event, then go to GAP.
  - GAP: GAP_CYCLES cycles with play=0 and pc=0.
    - If who!=0 on the last GAP cycle, go to IDLE (game ended on the player's move).
    - Otherwise go to SEARCH.
  - SEARCH: scans cells 0..8, one cell per cycle, index starting at 0.
    - First empty cell found: latch computer_position, go to C_STROBE.
    - Index 8 checked and occupied: go to IDLE with no pc (board full).
  - C_STROBE: pc=1 for HOLD_CYCLES cycles, then go to IDLE.
- sel events outside IDLE are dropped, not queued.
- player_position and computer_position hold their last latched values until the next latch.
- who becoming non-zero mid-SEARCH: abort to IDLE on the next cycle, with no pc.
- who becoming non-zero during a strobe: the strobe completes its full length.
- busy = (state != IDLE).

Test Plan (bench uses DEBOUNCE_CYCLES=4, HOLD_CYCLES=4, GAP_CYCLES=2):
- Reset then release; hold btn_next high 20 cycles -> cursor 0->1 exactly once; play/pc stay 0.
- From cursor 0: one prev press -> cursor=8. Then one next press -> cursor=0. Next and prev pressed together -> cursor unchanged.
- Empty board, cursor=4, press sel:
  - play high 4 cycles with player_position=4, then 2 gap cycles.
  - Model sets pos5=01; SEARCH finds cell 0, giving computer_position=0 and pc high 4 cycles.
  - busy low afterwards.
- pos1=01, cursor=0, press sel -> illegal=1 for one cycle; play stays 0; state stays IDLE.
- Board with only cell 8 empty, sel at 8:
  - play strobes and the model fills pos9.
  - SEARCH finds no empty cell -> no pc; back to IDLE after 9 search cycles.
- Assert reset during P_STROBE cycle 2 -> play=0 immediately, cursor=0, busy=0. Also: with who=01, sel is ignored (no play, no illegal).
